vrf_stream_reader: RTL and testbench

VRF_STREAM_READER -- requirements
Module: vrf_stream_reader

---
 rtl/vrf_stream_reader.sv | 135 +++++++++++++
 tb/tb_vrf_stream_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_stream_reader.sv
// Streams the elements of one vector register out of a combinational-read
// register file as a valid/ready element stream, one element per cycle.
module vrf_stream_reader #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_ELE    = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_vreg,
  input  logic [ADDR_WIDTH:0]   cmd_vl,
  output logic [ADDR_WIDTH-1:0] rf_raddr_reg,
  output logic [ADDR_WIDTH-1:0] rf_raddr_ele,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  out_last,
  output logic                  busy
);

  // Counter / length width: must hold the value NUM_ELE itself.
  localparam int unsigned CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] vreg_q;
  logic [CW-1:0]         vl_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         vl_clamp_c;
  logic                  accept_c;
  logic                  load_c;
  logic                  last_c;

  // Requested length saturated at the register size.
  assign vl_clamp_c = (cmd_vl > CW'(NUM_ELE)) ? CW'(NUM_ELE) : cmd_vl;

  // Element being loaded is the final one; compared as cnt+1 == vl to avoid underflow.
  assign last_c = (CW'(cnt_q + CW'(1)) == vl_q);

  // Read addresses come straight from the command and counter registers.
  assign rf_raddr_reg = vreg_q;
  assign rf_raddr_ele = cnt_q[ADDR_WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero-length command is accepted but never leaves IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c && (vl_clamp_c != '0)) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (load_c && last_c) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State decodes: handshake, busy flag and output-register load enable.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    load_c    = 1'b0;
    unique case (state_q)
      IDLE:    cmd_ready = 1'b1;
      STREAM: begin
        busy   = 1'b1;
        load_c = !out_valid || out_ready;
      end
      DRAIN:   busy = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
    accept_c = cmd_valid && cmd_ready;
  end

  // Command capture and element counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vreg_q <= '0;
      vl_q   <= '0;
      cnt_q  <= '0;
    end else if (accept_c) begin
      vreg_q <= cmd_vreg;
      vl_q   <= vl_clamp_c;
      cnt_q  <= '0;
    end else if (load_c) begin
      cnt_q  <= CW'(cnt_q + CW'(1));
    end
  end

  // Single-entry output register; holds its payload while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (load_c) begin
      out_valid <= 1'b1;
      out_data  <= rf_rdata;
      out_idx   <= cnt_q[ADDR_WIDTH-1:0];
      out_last  <= last_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vrf_stream_reader.sv
// Bench for vrf_stream_reader: regfile model, element scoreboard, command table
// and hand-written latency / ignore / reset sequences.
module tb_vrf_stream_reader;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NE = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_vreg;
  logic [AW:0]   cmd_vl;
  logic [AW-1:0] rf_raddr_reg;
  logic [AW-1:0] rf_raddr_ele;
  logic [DW-1:0] rf_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_last;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int rdy_mode = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;

  typedef struct {
    logic [AW-1:0] vreg;
    logic [AW:0]   vl;
    int            mode;
    int            exp_n;
  } row_t;

  exp_t sb[$];
  exp_t e;
  row_t rows[6];

  always #5 clk = ~clk;

  vrf_stream_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_ELE   (NE)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_vreg    (cmd_vreg),
    .cmd_vl      (cmd_vl),
    .rf_raddr_reg(rf_raddr_reg),
    .rf_raddr_ele(rf_raddr_ele),
    .rf_rdata    (rf_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .busy        (busy)
  );

  // Register file contents: reg 3 element i = 0x100+i, other regs tagged in upper bits.
  function automatic logic [DW-1:0] rf_val(input logic [AW-1:0] r, input logic [AW-1:0] i);
    return DW'((32'(r ^ AW'(3)) << 16) | (32'h100 + 32'(i)));
  endfunction

  assign rf_rdata = rf_val(rf_raddr_reg, rf_raddr_ele);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_expected(input logic [AW-1:0] vr, input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      x.data = rf_val(vr, AW'(i));
      x.idx  = AW'(i);
      x.last = (i == n - 1);
      sb.push_back(x);
    end
  endtask

  // Downstream ready generator: always, fixed 1,0,0,1,0,1 pattern, or random.
  initial begin
    logic [5:0] pat;
    int cyc;
    pat = 6'b101001;
    cyc = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       out_ready = pat[3'(cyc % 6)];
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      cyc++;
    end
  end

  // Output monitor: pops the scoreboard on each handshake and checks stall stability.
  logic          stall_q = 1'b0;
  logic [DW-1:0] h_data;
  logic [AW-1:0] h_idx;
  logic          h_last;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_stable", 64'({out_valid, out_data, out_idx, out_last}),
            64'({1'b1, h_data, h_idx, h_last}));
      end
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer act_idx=%0d act_data=%0h exp=none", out_idx, out_data);
        end else begin
          e = sb.pop_front();
          chk("xfer_data", 64'(out_data), 64'(e.data));
          chk("xfer_idx", 64'(out_idx), 64'(e.idx));
          chk("xfer_last", 64'(out_last), 64'(e.last));
        end
      end
      stall_q = out_valid && !out_ready;
      h_data  = out_data;
      h_idx   = out_idx;
      h_last  = out_last;
    end
  end

  task automatic send_cmd(input logic [AW-1:0] vr, input logic [AW:0] vl, input int n);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_vreg  = vr;
    cmd_vl    = vl;
    xfer_cnt  = 0;
    push_expected(vr, n);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int n);
    int cyc;
    cyc = 0;
    while (!(sb.size() == 0 && !busy && !out_valid) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 500) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout act_pending=%0d exp_pending=0", name, sb.size());
      sb.delete();
    end
    chk({name, "_count"}, 64'(xfer_cnt), 64'(n));
    chk({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic quiet(input string name);
    int seen;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    chk({name, "_quiet"}, 64'(seen), 64'd0);
  endtask

  initial begin
    int cyc;
    rows[0] = '{vreg: 5'd3,  vl: 6'd4,  mode: 1, exp_n: 4};
    rows[1] = '{vreg: 5'd3,  vl: 6'd0,  mode: 0, exp_n: 0};
    rows[2] = '{vreg: 5'd7,  vl: 6'd40, mode: 0, exp_n: 32};
    rows[3] = '{vreg: 5'd3,  vl: 6'd32, mode: 2, exp_n: 32};
    rows[4] = '{vreg: 5'd1,  vl: 6'd1,  mode: 1, exp_n: 1};
    rows[5] = '{vreg: 5'd31, vl: 6'd5,  mode: 2, exp_n: 5};

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_vreg  = '0;
    cmd_vl    = '0;
    rdy_mode  = 0;

    // Reset state.
    #12;
    chk("rst_out", 64'({out_valid, out_data, out_idx, out_last}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_raddr", 64'({rf_raddr_reg, rf_raddr_ele}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back burst: latency, no bubbles, cmd_ready returns right after.
    send_cmd(5'd3, 6'd4, 4);
    @(negedge clk);
    chk("lat_valid_early", 64'(out_valid), 64'd0);
    chk("lat_busy", 64'(busy), 64'd1);
    chk("lat_cmd_ready", 64'(cmd_ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("burst_valid", 64'(out_valid), 64'd1);
      chk("burst_idx", 64'(out_idx), 64'(k));
    end
    @(negedge clk);
    chk("burst_end_ready", 64'(cmd_ready), 64'd1);
    chk("burst_end_valid", 64'(out_valid), 64'd0);
    chk("burst_end_busy", 64'(busy), 64'd0);
    wait_done("burst", 4);

    // Command table.
    for (int r = 0; r < 6; r++) begin
      rdy_mode = rows[r].mode;
      send_cmd(rows[r].vreg, rows[r].vl, rows[r].exp_n);
      @(negedge clk);
      chk("row_busy", 64'(busy), 64'(rows[r].exp_n != 0));
      chk("row_cmd_ready", 64'(cmd_ready), 64'(rows[r].exp_n == 0));
      wait_done("row", rows[r].exp_n);
      rdy_mode = 0;
      quiet("row");
    end

    // Command offered mid-stream must be dropped.
    rdy_mode = 1;
    send_cmd(5'd3, 6'd8, 8);
    repeat (3) @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_vreg  = 5'd5;
    cmd_vl    = 6'd2;
    @(negedge clk);
    chk("ign_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done("ignored", 8);
    rdy_mode = 0;
    quiet("ignored");

    // Reset mid-stream, then a fresh command.
    send_cmd(5'd3, 6'd8, 8);
    cyc = 0;
    while (xfer_cnt < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reached", 64'(xfer_cnt >= 2), 64'd1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out", 64'({out_valid, out_data, out_idx, out_last}), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_raddr", 64'({rf_raddr_reg, rf_raddr_ele}), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    chk("mid_rst_hold", 64'({out_valid, busy}), 64'd0);
    reset_n = 1'b1;
    send_cmd(5'd5, 6'd2, 2);
    wait_done("post_rst", 2);
    quiet("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
